// File: rtl/fir_dec_pkg.sv
// Shared defaults and helpers for the FIR output decimator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds default parameter values, a constant-evaluable clog2, the
// accumulator width derivation and the output saturation constant.
package fir_dec_pkg;

    localparam int IN_WIDTH_DEF   = 16;
    localparam int DEC_MAX_DEF    = 16;
    localparam int OUT_WIDTH_DEF  = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    // Smallest r with 2**r >= value; constant-evaluable for parameter math.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Largest value representable in an unsigned field of the given width.
    function automatic int sat_value(input int width);
        return (1 << width) - 1;
    endfunction

    // Window sum of DEC_MAX full-scale samples fits without overflow.
    localparam int ACC_WIDTH_DEF = IN_WIDTH_DEF + clog2(DEC_MAX_DEF);
    localparam int SAT_VAL_DEF   = sat_value(OUT_WIDTH_DEF);

endpackage

// File: rtl/fir_dec_fifo.sv
// First-word-fall-through result FIFO; head is visible on pop_dat whenever !empty.
// Latency: push at edge k is visible on pop_dat after edge k.
// Backpressure: push while full is ignored unless a pop happens the same edge.
//
// Ports: clk, rst_n (async active-low), push/push_dat, pop/pop_dat, full, empty.
// Pointers carry one extra wrap bit to tell full from empty.
module fir_dec_fifo
    import fir_dec_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees the slot the simultaneous push lands in, so full+pop still accepts.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Head reads as zero when empty so the output is clean out of reset.
    assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_dec_out.sv
// Integrate-and-dump decimator on FIR output: window sum, shift, round, saturate, FIFO.
// Latency: last window sample at edge k -> sum registered at k -> FIFO write at k+1.
// Backpressure: none on input; results dropped when FIFO full (sticky ovf), out valid/ready.
//
// Ports: clk, rst_n (async active-low), in_data/in_valid, dec_sel (ratio-1),
//        shift, out_data/out_valid/out_ready, ovf/ovf_clr.
// Optional macro FIR_DEC_ROUND_EN: round half up before the shift (default truncates).
module fir_dec_out
    import fir_dec_pkg::*;
#(
    parameter int IN_WIDTH   = IN_WIDTH_DEF,
    parameter int DEC_MAX    = DEC_MAX_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [IN_WIDTH-1:0]        in_data,
    input  logic                       in_valid,
    input  logic [clog2(DEC_MAX)-1:0]  dec_sel,
    input  logic [3:0]                 shift,
    output logic [OUT_WIDTH-1:0]       out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    localparam int DSEL_W    = clog2(DEC_MAX);
    localparam int ACC_WIDTH = IN_WIDTH + DSEL_W;
    localparam logic [OUT_WIDTH-1:0] SAT_VAL = OUT_WIDTH'(sat_value(OUT_WIDTH));

    // Window state
    logic [DSEL_W-1:0]    cnt;
    logic [DSEL_W-1:0]    ratio_lat;
    logic [3:0]           shift_lat;
    logic [ACC_WIDTH-1:0] acc;

    // Dump register: completed window sum plus the shift that belongs to it
    logic                 dump_vld;
    logic [ACC_WIDTH-1:0] sum_q;
    logic [3:0]           dump_shift;

    logic                 first;
    logic                 last;
    logic [DSEL_W-1:0]    win_ratio;
    logic [3:0]           win_shift;
    logic [ACC_WIDTH-1:0] in_ext;
    logic [ACC_WIDTH-1:0] acc_next;

    // On the first sample of a window the live controls apply directly, since
    // the latched copies only become valid after this edge.
    assign first     = (cnt == '0);
    assign win_ratio = first ? dec_sel : ratio_lat;
    assign win_shift = first ? shift   : shift_lat;
    assign last      = (cnt == win_ratio);
    assign in_ext    = {{DSEL_W{1'b0}}, in_data};
    assign acc_next  = first ? in_ext : (acc + in_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            ratio_lat  <= '0;
            shift_lat  <= '0;
            acc        <= '0;
            dump_vld   <= 1'b0;
            sum_q      <= '0;
            dump_shift <= '0;
        end else begin
            dump_vld <= in_valid & last;
            if (in_valid) begin
                acc <= acc_next;
                if (first) begin
                    ratio_lat <= dec_sel;
                    shift_lat <= shift;
                end
                if (last) begin
                    cnt        <= '0;
                    sum_q      <= acc_next;
                    dump_shift <= win_shift;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Scaler: one extra bit keeps the rounding carry out of the saturation test.
    logic [ACC_WIDTH:0]   sum_ext;
    logic [ACC_WIDTH:0]   scaled;
    logic [OUT_WIDTH-1:0] result;

    assign sum_ext = {1'b0, sum_q};

`ifdef FIR_DEC_ROUND_EN
    logic [ACC_WIDTH:0] round_term;

    always_comb begin
        round_term = '0;
        if (dump_shift != 4'd0) begin
            round_term = {{ACC_WIDTH{1'b0}}, 1'b1} << (dump_shift - 4'd1);
        end
    end

    assign scaled = (sum_ext + round_term) >> dump_shift;
`else
    assign scaled = sum_ext >> dump_shift;
`endif

    assign result = (|scaled[ACC_WIDTH:OUT_WIDTH]) ? SAT_VAL : scaled[OUT_WIDTH-1:0];

    // Result FIFO and overrun tracking
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic drop;

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign drop      = dump_vld & fifo_full & ~pop;

    fir_dec_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (dump_vld),
        .push_dat (result),
        .pop      (pop),
        .pop_dat  (out_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // A fresh drop outranks a simultaneous clear so no overrun goes unreported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule
